// File: rtl/led_seq_pkg.sv
// Shared register map, CTRL/STATUS bit positions and FSM state type for the
// red-LED sequencer.
package led_seq_pkg;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_DWELL  = 3'd2;
    localparam logic [2:0] ADDR_LENGTH = 3'd3;
    localparam logic [2:0] ADDR_TADDR  = 3'd4;
    localparam logic [2:0] ADDR_TDATA  = 3'd5;
    localparam logic [2:0] ADDR_MANUAL = 3'd6;

    localparam int CTRL_RUN     = 0;
    localparam int CTRL_LOOP    = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int STAT_RUNNING = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_IDX_LSB = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

    // A sequence always has at least one step and never more than the table holds.
    function automatic logic [31:0] clamp_length(input logic [31:0] v, input logic [31:0] depth);
        if (v == 32'd0)
            return 32'd1;
        else if (v > depth)
            return depth;
        return v;
    endfunction

endpackage

// File: rtl/led_seq_table.sv
// Pattern table: DEPTH x LED_W register file, one write port, two async read
// ports (bus readback and step load). Contents are deliberately not reset.
module led_seq_table #(
    parameter int LED_W = 18,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [LED_W-1:0] wdata,
    input  logic [AW-1:0]    raddr_bus,
    output logic [LED_W-1:0] rdata_bus,
    input  logic [AW-1:0]    raddr_load,
    output logic [LED_W-1:0] rdata_load
);

    logic [LED_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata_bus  = mem[raddr_bus];
    assign rdata_load = mem[raddr_load];

endmodule

// File: rtl/led_red_sequencer.sv
// Avalon-MM red-LED pattern sequencer: bus decode, step FSM and dwell counter.
// Define LED_RED_SEQUENCER_IRQ_EN to add the completion interrupt (irq, CTRL bit2).
module led_red_sequencer
    import led_seq_pkg::*;
#(
    parameter int LED_W = 18,
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
`ifdef LED_RED_SEQUENCER_IRQ_EN
    output logic             irq,
`endif
    output logic [LED_W-1:0] out_port
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          LW      = AW + 1;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    seq_state_e       state, state_nx;
    logic [AW-1:0]    idx, idx_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [LED_W-1:0] out_q, out_nx;
    logic             done_q, done_nx;

    logic             loop_q;
    logic [CNT_W-1:0] dwell_q;
    logic [LW-1:0]    length_q;
    logic [AW-1:0]    taddr_q;
    logic [LED_W-1:0] manual_q, manual_nx;

    logic             wr, ctrl_wr, status_wr, tdata_wr;
    logic [LW-1:0]    idx_inc;
    logic             has_next;
    logic [CNT_W-1:0] d_m1;
    logic [AW-1:0]    load_addr;
    logic [LED_W-1:0] load_data, bus_data;

    assign wr        = chipselect & ~write_n;
    assign ctrl_wr   = wr && (address == ADDR_CTRL);
    assign status_wr = wr && (address == ADDR_STATUS);
    assign tdata_wr  = wr && (address == ADDR_TDATA);
    assign manual_nx = (wr && address == ADDR_MANUAL) ? writedata[LED_W-1:0] : manual_q;

    assign idx_inc  = LW'(idx) + LW'(1);
    assign has_next = idx_inc < length_q;
    // Counter reload value for effective dwell max(DWELL,1).
    assign d_m1     = (dwell_q == '0) ? '0 : dwell_q - CNT_W'(1);

    // Only a non-wrapping boundary loads something other than entry 0.
    assign load_addr = (!ctrl_wr && state == RUN && cnt == '0 && has_next) ? idx_inc[AW-1:0] : '0;

    led_seq_table #(
        .LED_W (LED_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_table (
        .clk        (clk),
        .we         (tdata_wr),
        .waddr      (taddr_q),
        .wdata      (writedata[LED_W-1:0]),
        .raddr_bus  (taddr_q),
        .rdata_bus  (bus_data),
        .raddr_load (load_addr),
        .rdata_load (load_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loop_q   <= 1'b0;
            dwell_q  <= '0;
            length_q <= LW'(1);
            taddr_q  <= '0;
            manual_q <= '0;
        end else begin
            manual_q <= manual_nx;
            if (ctrl_wr)
                loop_q <= writedata[CTRL_LOOP];
            if (wr && address == ADDR_DWELL)
                dwell_q <= writedata[CNT_W-1:0];
            if (wr && address == ADDR_LENGTH)
                length_q <= LW'(clamp_length(writedata, DEPTH_W));
            if (wr && address == ADDR_TADDR)
                taddr_q <= writedata[AW-1:0];
            else if (tdata_wr)
                taddr_q <= taddr_q + AW'(1);
        end
    end

    // A CTRL write always wins over a step boundary in the same cycle.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt;
        out_nx   = out_q;
        done_nx  = status_wr ? 1'b0 : done_q;
        if (ctrl_wr) begin
            idx_nx = '0;
            if (writedata[CTRL_RUN]) begin
                state_nx = RUN;
                cnt_nx   = d_m1;
                out_nx   = load_data;
                done_nx  = 1'b0;
            end else begin
                state_nx = IDLE;
                out_nx   = manual_nx;
            end
        end else begin
            case (state)
                IDLE: out_nx = manual_nx;
                RUN: begin
                    if (cnt != '0) begin
                        cnt_nx = cnt - CNT_W'(1);
                    end else if (has_next) begin
                        idx_nx = idx_inc[AW-1:0];
                        cnt_nx = d_m1;
                        out_nx = load_data;
                    end else if (loop_q) begin
                        idx_nx = '0;
                        cnt_nx = d_m1;
                        out_nx = load_data;
                    end else begin
                        state_nx = IDLE;
                        idx_nx   = '0;
                        done_nx  = 1'b1;
                        out_nx   = manual_nx;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= '0;
            cnt    <= '0;
            out_q  <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            cnt    <= cnt_nx;
            out_q  <= out_nx;
            done_q <= done_nx;
        end
    end

    assign out_port = out_q;

`ifdef LED_RED_SEQUENCER_IRQ_EN
    logic irq_en_q, irq_en_nx;

    assign irq_en_nx = ctrl_wr ? writedata[CTRL_IRQ_EN] : irq_en_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            irq      <= 1'b0;
        end else begin
            irq_en_q <= irq_en_nx;
            irq      <= done_nx & irq_en_nx;
        end
    end
`endif

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL: begin
                readdata[CTRL_RUN]  = (state == RUN);
                readdata[CTRL_LOOP] = loop_q;
`ifdef LED_RED_SEQUENCER_IRQ_EN
                readdata[CTRL_IRQ_EN] = irq_en_q;
`endif
            end
            ADDR_STATUS: begin
                readdata[STAT_RUNNING]         = (state == RUN);
                readdata[STAT_DONE]            = done_q;
                readdata[STAT_IDX_LSB +: AW]   = idx;
            end
            ADDR_DWELL:  readdata = 32'(dwell_q);
            ADDR_LENGTH: readdata = 32'(length_q);
            ADDR_TADDR:  readdata = 32'(taddr_q);
            ADDR_TDATA:  readdata = 32'(bus_data);
            ADDR_MANUAL: readdata = 32'(manual_q);
            default:     readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_led_red_sequencer.sv
// Scoreboard bench for led_red_sequencer: expectations are queued as stimulus
// is applied and popped as register reads / LED samples come back.
module tb_led_red_sequencer;
    import led_seq_pkg::*;

    localparam int LED_W = 18;
    localparam int DEPTH = 8;
    localparam int CNT_W = 32;
    localparam logic [31:0] MAN = 32'h2AAAA;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [2:0]       address = '0;
    logic             chipselect = 1'b0;
    logic             write_n = 1'b1;
    logic [31:0]      writedata = '0;
    logic [31:0]      readdata;
    logic [LED_W-1:0] out_port;
`ifdef LED_RED_SEQUENCER_IRQ_EN
    logic             irq;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    led_red_sequencer #(.LED_W(LED_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
`ifdef LED_RED_SEQUENCER_IRQ_EN
        .irq        (irq),
`endif
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1;
        #1;
        d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic test_reset;
        logic [2:0]  addrs [7] = '{ADDR_CTRL, ADDR_STATUS, ADDR_DWELL, ADDR_LENGTH, ADDR_TADDR, ADDR_MANUAL, 3'd7};
        logic [31:0] vals  [7] = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0};
        logic [31:0] got, exp;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 7; i++) exp_q.push_back(vals[i]);
        for (int i = 0; i < 7; i++) begin
            bus_rd(addrs[i], got);
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL reset_reg[%0d] got=%h want=%h", addrs[i], got, exp);
            end
        end
        exp_q.push_back(32'd0);
        exp = exp_q.pop_front();
        total++;
        if (32'(out_port) !== exp) begin
            bad++;
            $display("FAIL reset_out got=%h want=%h", out_port, exp);
        end
    endtask

    task automatic test_manual;
        logic [31:0] got, exp;
        exp_q.push_back(MAN);
        exp_q.push_back(MAN);
        bus_wr(ADDR_MANUAL, MAN);
        exp = exp_q.pop_front();
        total++;
        if (32'(out_port) !== exp) begin
            bad++;
            $display("FAIL manual_out got=%h want=%h", out_port, exp);
        end
        bus_rd(ADDR_MANUAL, got);
        exp = exp_q.pop_front();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL manual_rd got=%h want=%h", got, exp);
        end
    endtask

    task automatic test_single_run;
        logic [31:0] got, exp;
        logic [2:0]  ra [3] = '{ADDR_STATUS, ADDR_CTRL, ADDR_STATUS};
        bus_wr(ADDR_TADDR, 0);
        bus_wr(ADDR_TDATA, 32'h1);
        bus_wr(ADDR_TDATA, 32'h2);
        bus_wr(ADDR_TDATA, 32'h4);
        bus_wr(ADDR_LENGTH, 3);
        bus_wr(ADDR_DWELL, 4);
        for (int s = 0; s < 3; s++)
            for (int c = 0; c < 4; c++) exp_q.push_back(32'h1 << s);
        exp_q.push_back(MAN);
        bus_wr(ADDR_CTRL, 32'h1);
        for (int i = 0; i < 13; i++) begin
            exp = exp_q.pop_front();
            total++;
            if (32'(out_port) !== exp) begin
                bad++;
                $display("FAIL once_step[%0d] got=%h want=%h", i, out_port, exp);
            end
            @(negedge clk);
        end
        exp_q.push_back(32'h2);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) bus_wr(ADDR_STATUS, 32'h0);
            bus_rd(ra[i], got);
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL once_reg[%0d] got=%h want=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_loop;
        logic [31:0] got, exp;
        bus_wr(ADDR_DWELL, 0);
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < 3; s++) exp_q.push_back(32'h1 << s);
        bus_wr(ADDR_CTRL, 32'h3);
        for (int i = 0; i < 6; i++) begin
            exp = exp_q.pop_front();
            total++;
            if (32'(out_port) !== exp) begin
                bad++;
                $display("FAIL loop_step[%0d] got=%h want=%h", i, out_port, exp);
            end
            @(negedge clk);
        end
        exp_q.push_back(MAN);
        exp_q.push_back(32'h0);
        bus_wr(ADDR_CTRL, 32'h0);
        exp = exp_q.pop_front();
        total++;
        if (32'(out_port) !== exp) begin
            bad++;
            $display("FAIL loop_stop_out got=%h want=%h", out_port, exp);
        end
        bus_rd(ADDR_STATUS, got);
        exp = exp_q.pop_front();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL loop_stop_status got=%h want=%h", got, exp);
        end
    endtask

    task automatic test_length_taddr;
        logic [2:0]  wa [9] = '{ADDR_LENGTH, ADDR_LENGTH, ADDR_LENGTH, ADDR_TADDR, ADDR_TDATA, ADDR_TDATA, ADDR_TADDR, ADDR_TADDR, ADDR_TADDR};
        logic [31:0] wd [9] = '{32'd0, 32'd12, 32'd8, 32'd7, 32'h11, 32'h22, 32'd1, 32'd7, 32'd0};
        logic [2:0]  ra [9] = '{ADDR_LENGTH, ADDR_LENGTH, ADDR_LENGTH, ADDR_TADDR, ADDR_TADDR, ADDR_TADDR, ADDR_TDATA, ADDR_TDATA, ADDR_TDATA};
        logic [31:0] ev [9] = '{32'd1, 32'd8, 32'd8, 32'd7, 32'd0, 32'd1, 32'h2, 32'h11, 32'h22};
        logic [31:0] got, exp;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(ev[i]);
            bus_wr(wa[i], wd[i]);
            bus_rd(ra[i], got);
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL len_taddr[%0d] got=%h want=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_reset_midrun;
        logic [31:0] got, exp;
        bus_wr(ADDR_LENGTH, 3);
        bus_wr(ADDR_DWELL, 2);
        bus_wr(ADDR_CTRL, 32'h1);
        repeat (4) @(negedge clk);
        exp_q.push_back(32'h201);
        exp_q.push_back(32'h4);
        bus_rd(ADDR_STATUS, got);
        exp = exp_q.pop_front();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL mid_status got=%h want=%h", got, exp);
        end
        exp = exp_q.pop_front();
        total++;
        if (32'(out_port) !== exp) begin
            bad++;
            $display("FAIL mid_out got=%h want=%h", out_port, exp);
        end
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        reset = 1'b1;
        #1;
        exp = exp_q.pop_front();
        total++;
        if (32'(out_port) !== exp) begin
            bad++;
            $display("FAIL async_rst_out got=%h want=%h", out_port, exp);
        end
        bus_rd(ADDR_STATUS, got);
        exp = exp_q.pop_front();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL async_rst_status got=%h want=%h", got, exp);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        bus_rd(ADDR_STATUS, got);
        exp = exp_q.pop_front();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL post_rst_status got=%h want=%h", got, exp);
        end
        bus_rd(ADDR_LENGTH, got);
        exp = exp_q.pop_front();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL post_rst_length got=%h want=%h", got, exp);
        end
    endtask

`ifdef LED_RED_SEQUENCER_IRQ_EN
    task automatic test_irq;
        logic [31:0] got, exp;
        bus_wr(ADDR_LENGTH, 2);
        exp_q.push_back({13'd0, 1'b0, 18'h22});
        exp_q.push_back({13'd0, 1'b0, 18'h2});
        exp_q.push_back({13'd0, 1'b1, 18'h0});
        bus_wr(ADDR_CTRL, 32'h5);
        for (int i = 0; i < 3; i++) begin
            exp = exp_q.pop_front();
            total++;
            if (32'({irq, out_port}) !== exp) begin
                bad++;
                $display("FAIL irq_step[%0d] got=%h want=%h", i, {irq, out_port}, exp);
            end
            @(negedge clk);
        end
        exp_q.push_back(32'h2);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        bus_rd(ADDR_STATUS, got);
        exp = exp_q.pop_front();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL irq_status got=%h want=%h", got, exp);
        end
        bus_rd(ADDR_CTRL, got);
        exp = exp_q.pop_front();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL irq_ctrl got=%h want=%h", got, exp);
        end
        bus_wr(ADDR_STATUS, 32'h0);
        exp = exp_q.pop_front();
        total++;
        if (32'(irq) !== exp) begin
            bad++;
            $display("FAIL irq_clear got=%h want=%h", irq, exp);
        end
        bus_rd(ADDR_STATUS, got);
        exp = exp_q.pop_front();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL irq_done_clear got=%h want=%h", got, exp);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_manual();
        test_single_run();
        test_loop();
        test_length_taddr();
        test_reset_midrun();
`ifdef LED_RED_SEQUENCER_IRQ_EN
        test_irq();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
